// File: rtl/hazard_stall_unit.sv
// Stall-side pipeline hazard control: one-bubble load-use stalls, whole-pipe freeze while data
// memory is busy, a saturating stall-cycle counter and a sticky memory-timeout error.
module hazard_stall_unit #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             id_ex_mr,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_mem_mr,
  input  logic             ex_mem_mw,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]     stall_count_q, stall_count_d;
  logic                 mem_err_q, mem_err_d;

  logic lu;
  logic mem_busy;
  logic pc_write_fsm, if_id_write_fsm, id_ex_bubble_fsm, pipe_hold_fsm;

  // $zero is never a real producer, so a load targeting r0 cannot create a hazard.
  assign lu = id_ex_mr && (id_ex_rt != 5'd0) &&
              ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  assign mem_busy = (ex_mem_mr || ex_mem_mw) && !dmem_ready;

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    mem_err_d        = mem_err_q;
    pc_write_fsm     = 1'b1;
    if_id_write_fsm  = 1'b1;
    id_ex_bubble_fsm = 1'b0;
    pipe_hold_fsm    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          pc_write_fsm    = 1'b0;
          if_id_write_fsm = 1'b0;
          pipe_hold_fsm   = 1'b1;
          state_d         = ST_MEM_WAIT;
          wait_cnt_d      = TIMEOUT_W'(1);
        end else if (lu) begin
          pc_write_fsm     = 1'b0;
          if_id_write_fsm  = 1'b0;
          id_ex_bubble_fsm = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          // Release in the ready cycle itself; a pending load-use still gets its bubble.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          if (lu) begin
            pc_write_fsm     = 1'b0;
            if_id_write_fsm  = 1'b0;
            id_ex_bubble_fsm = 1'b1;
          end
        end else begin
          pc_write_fsm    = 1'b0;
          if_id_write_fsm = 1'b0;
          pipe_hold_fsm   = 1'b1;
          if (wait_cnt_q == TIMEOUT_VAL) begin
            state_d   = ST_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
          end
        end
      end

      ST_ERR: begin
        pc_write_fsm    = 1'b0;
        if_id_write_fsm = 1'b0;
        pipe_hold_fsm   = 1'b1;
      end

      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // While reset is asserted the pipeline is frozen regardless of inputs.
  always_comb begin
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b1;
    end else begin
      pc_write     = pc_write_fsm;
      if_id_write  = if_id_write_fsm;
      id_ex_bubble = id_ex_bubble_fsm;
      pipe_hold    = pipe_hold_fsm;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign stall_count = stall_count_q;
  assign mem_err     = mem_err_q;
  assign dbg_state   = state_q;

endmodule
